// File: rtl/spike_rate_decoder.sv
// Converts a 1-bit spike stream into per-window spike counts and the latest
// inter-spike interval, delivered through a single-entry valid/ready buffer.
module spike_rate_decoder #(
  parameter int COUNT_W  = 8,
  parameter int ISI_W    = 8,
  parameter int WINDOW_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                spike_in,
  input  logic [WINDOW_W-1:0] window_len,
  output logic [COUNT_W-1:0]  rate_out,
  output logic [ISI_W-1:0]    isi_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun
);

  typedef enum logic {START, RUN} state_t;

  state_t              state_reg, state_next;
  logic [WINDOW_W-1:0] len_reg, len_next;
  logic [WINDOW_W-1:0] win_cnt_reg, win_cnt_next;
  logic [COUNT_W-1:0]  spike_cnt_reg, spike_cnt_next;
  logic [ISI_W-1:0]    isi_cnt_reg, isi_cnt_next;
  logic [ISI_W-1:0]    last_isi_reg, last_isi_next;
  logic                seen_reg, seen_next;
  logic [COUNT_W-1:0]  rate_reg, rate_next;
  logic [ISI_W-1:0]    isi_out_reg, isi_out_next;
  logic                valid_reg, valid_next;
  logic                overrun_reg, overrun_next;

  logic                last_cycle;
  logic                close;
  logic [COUNT_W-1:0]  count_base;
  logic [ISI_W-1:0]    isi_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= START;
      len_reg       <= '0;
      win_cnt_reg   <= '0;
      spike_cnt_reg <= '0;
      isi_cnt_reg   <= '0;
      last_isi_reg  <= '1;
      seen_reg      <= 1'b0;
      rate_reg      <= '0;
      isi_out_reg   <= '1;
      valid_reg     <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      win_cnt_reg   <= win_cnt_next;
      spike_cnt_reg <= spike_cnt_next;
      isi_cnt_reg   <= isi_cnt_next;
      last_isi_reg  <= last_isi_next;
      seen_reg      <= seen_next;
      rate_reg      <= rate_next;
      isi_out_reg   <= isi_out_next;
      valid_reg     <= valid_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    win_cnt_next   = win_cnt_reg;
    spike_cnt_next = spike_cnt_reg;
    isi_cnt_next   = isi_cnt_reg;
    last_isi_next  = last_isi_reg;
    seen_next      = seen_reg;
    rate_next      = rate_reg;
    isi_out_next   = isi_out_reg;
    valid_next     = valid_reg;
    overrun_next   = overrun_reg;
    last_cycle     = 1'b0;
    count_base     = spike_cnt_reg;
    isi_inc        = (isi_cnt_reg == '1) ? isi_cnt_reg : isi_cnt_reg + ISI_W'(1);

    if (ena) begin
      case (state_reg)
        START: begin
          // START is window cycle 0: fresh length, fresh count
          len_next   = window_len;
          count_base = '0;
          if (window_len == '0) begin
            last_cycle   = 1'b1;
            win_cnt_next = '0;
          end else begin
            state_next   = RUN;
            win_cnt_next = WINDOW_W'(1);
          end
        end
        RUN: begin
          if (win_cnt_reg == len_reg) begin
            last_cycle   = 1'b1;
            state_next   = START;
            win_cnt_next = '0;
          end else begin
            win_cnt_next = win_cnt_reg + WINDOW_W'(1);
          end
        end
        default: state_next = START;
      endcase

      if (spike_in && count_base != '1)
        spike_cnt_next = count_base + COUNT_W'(1);
      else
        spike_cnt_next = count_base;

      if (spike_in) begin
        if (seen_reg) last_isi_next = isi_inc;
        isi_cnt_next = '0;
        seen_next    = 1'b1;
      end else begin
        isi_cnt_next = isi_inc;
      end
    end

    close = ena && last_cycle;

    if (valid_reg && out_ready) valid_next = 1'b0;

    // A close may refill the buffer in the same cycle it is being drained
    if (close) begin
      if (!valid_reg || out_ready) begin
        rate_next    = spike_cnt_next;
        isi_out_next = last_isi_next;
        valid_next   = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  assign rate_out  = rate_reg;
  assign isi_out   = isi_out_reg;
  assign out_valid = valid_reg;
  assign overrun   = overrun_reg;

endmodule
